// File: rtl/matrix_frame_buf.sv
// matrix_frame_buf: double-buffered 8x8 frame store; swaps back->front on frame_sync or sync timeout.
// Define MATRIX_FRAME_BUF_READBACK_EN to add registered back-buffer readback (rd_row/rd_data).
module matrix_frame_buf #(
    parameter bit          COPY_ON_SWAP = 1'b1,
    parameter int unsigned SYNC_TIMEOUT = 1048576,
    parameter int          TO_W         = 21
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [2:0]  wr_row,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    input  logic        commit,
    input  logic        frame_sync,
    output logic [63:0] frame,
    output logic        pending,
    output logic        swap_done,
    output logic        forced
`ifdef MATRIX_FRAME_BUF_READBACK_EN
    ,
    input  logic [2:0]  rd_row,
    output logic [7:0]  rd_data
`endif
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;
    state_t          state_q;
    logic [63:0]     front_q, back_q;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            swap_done_q, forced_q, timeout, swap;

    assign timeout = (SYNC_TIMEOUT != 0) && (cnt_q == TO_W'(SYNC_TIMEOUT - 1));
    assign swap    = (state_q == S_WAIT) && (frame_sync || timeout);
    assign cnt_d   = &cnt_q ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            front_q     <= '0;
            back_q      <= '0;
            cnt_q       <= '0;
            swap_done_q <= 1'b0;
            forced_q    <= 1'b0;
        end else begin
            swap_done_q <= swap;
            if (state_q == S_IDLE) begin
                if (wr_en) back_q[{wr_row, 3'b000} +: 8] <= wr_data;
                if (commit) begin
                    state_q <= S_WAIT;
                    cnt_q   <= '0;
                end
            end else begin
                cnt_q <= cnt_d;
                if (swap) begin
                    front_q <= back_q;
                    if (!COPY_ON_SWAP) back_q <= front_q;
                    // a real frame_sync arriving on the timeout cycle is not a forced swap
                    if (timeout && !frame_sync) forced_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            end
        end
    end

    assign frame     = front_q;
    assign pending   = (state_q == S_WAIT);
    assign wr_ready  = (state_q == S_IDLE);
    assign swap_done = swap_done_q;
    assign forced    = forced_q;

`ifdef MATRIX_FRAME_BUF_READBACK_EN
    logic [7:0] rd_data_q;
    always_ff @(posedge clk) begin
        if (rst) rd_data_q <= '0;
        else     rd_data_q <= back_q[{rd_row, 3'b000} +: 8];
    end
    assign rd_data = rd_data_q;
`endif
endmodule

// File: tb/tb_matrix_frame_buf.sv
// tb_matrix_frame_buf: directed tests for matrix_frame_buf (incremental instance with
// 16-cycle timeout, plus a ping-pong instance with the timeout disabled).
module tb_matrix_frame_buf;
    logic        clk = 1'b0;
    logic        rst, wr_en, commit, frame_sync;
    logic [2:0]  wr_row;
    logic [7:0]  wr_data;
    logic        wr_ready, pending, swap_done, forced;
    logic [63:0] frame;
    logic        p_rst, p_wr_en, p_commit, p_sync;
    logic [2:0]  p_wr_row;
    logic [7:0]  p_wr_data;
    logic        p_wr_ready, p_pending, p_swap_done, p_forced;
    logic [63:0] p_frame;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    matrix_frame_buf #(.COPY_ON_SWAP(1'b1), .SYNC_TIMEOUT(16), .TO_W(5)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
        .wr_ready(wr_ready), .commit(commit), .frame_sync(frame_sync), .frame(frame),
        .pending(pending), .swap_done(swap_done), .forced(forced)
    );

    matrix_frame_buf #(.COPY_ON_SWAP(1'b0), .SYNC_TIMEOUT(0), .TO_W(5)) dut_pp (
        .clk(clk), .rst(p_rst), .wr_en(p_wr_en), .wr_row(p_wr_row), .wr_data(p_wr_data),
        .wr_ready(p_wr_ready), .commit(p_commit), .frame_sync(p_sync), .frame(p_frame),
        .pending(p_pending), .swap_done(p_swap_done), .forced(p_forced)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; p_rst = 1'b1;
        tick(); tick();
        rst = 1'b0; p_rst = 1'b0;
        tests++;
        if (frame !== 64'h0) begin fails++; $display("FAIL reset_frame got %h exp 0", frame); end
        tests++;
        if ({pending, wr_ready, swap_done, forced} !== 4'b0100) begin
            fails++; $display("FAIL reset_flags got %b exp 0100", {pending, wr_ready, swap_done, forced});
        end
        tests++;
        if ({p_frame, p_pending, p_wr_ready} !== {64'h0, 2'b01}) begin
            fails++; $display("FAIL reset_pp got %h %b exp 0 01", p_frame, {p_pending, p_wr_ready});
        end
    endtask

    task automatic test_write_commit();
        for (int r = 0; r < 8; r++) begin
            wr_en = 1'b1; wr_row = 3'(r); wr_data = 8'(1 << r);
            commit = (r == 7);
            tick();
        end
        wr_en = 1'b0; commit = 1'b0;
        tests++;
        if ({pending, wr_ready} !== 2'b10) begin fails++; $display("FAIL commit_pending got %b exp 10", {pending, wr_ready}); end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if ({frame, pending, swap_done} !== {64'h0, 2'b10}) begin
                fails++; $display("FAIL wait_hold got %h %b exp 0 10", frame, {pending, swap_done});
            end
        end
        frame_sync = 1'b1; tick(); frame_sync = 1'b0;
        tests++;
        if (frame !== 64'h8040201008040201) begin fails++; $display("FAIL swap_frame got %h exp 8040201008040201", frame); end
        tests++;
        if ({swap_done, pending, wr_ready} !== 3'b101) begin
            fails++; $display("FAIL swap_flags got %b exp 101", {swap_done, pending, wr_ready});
        end
        tick();
        tests++;
        if (swap_done !== 1'b0) begin fails++; $display("FAIL swap_done_pulse got %b exp 0", swap_done); end
    endtask

    task automatic test_wait_write_drop();
        commit = 1'b1; tick(); commit = 1'b0;
        wr_en = 1'b1; wr_row = 3'd3; wr_data = 8'hFF;
        tests++;
        if (wr_ready !== 1'b0) begin fails++; $display("FAIL wait_ready got %b exp 0", wr_ready); end
        tick(); wr_en = 1'b0;
        frame_sync = 1'b1; tick(); frame_sync = 1'b0;
        tests++;
        if (frame[31:24] !== 8'h08) begin fails++; $display("FAIL drop_row3 got %h exp 08", frame[31:24]); end
        commit = 1'b1; tick(); commit = 1'b0;
        frame_sync = 1'b1; tick(); frame_sync = 1'b0;
        tests++;
        if (frame !== 64'h8040201008040201) begin fails++; $display("FAIL drop_back got %h exp 8040201008040201", frame); end
    endtask

    task automatic test_commit_sync_same();
        wr_en = 1'b1; wr_row = 3'd0; wr_data = 8'hAA; commit = 1'b1; frame_sync = 1'b1;
        tick();
        wr_en = 1'b0; commit = 1'b0; frame_sync = 1'b0;
        tests++;
        if ({frame, pending, swap_done} !== {64'h8040201008040201, 2'b10}) begin
            fails++; $display("FAIL same_cycle got %h %b exp 8040201008040201 10", frame, {pending, swap_done});
        end
        tick(); tick();
        tests++;
        if (pending !== 1'b1) begin fails++; $display("FAIL same_cycle_wait got %b exp 1", pending); end
        frame_sync = 1'b1; tick(); frame_sync = 1'b0;
        tests++;
        if ({frame, swap_done} !== {64'h80402010080402AA, 1'b1}) begin
            fails++; $display("FAIL same_cycle_swap got %h %b exp 80402010080402aa 1", frame, swap_done);
        end
    endtask

    task automatic test_timeout();
        tests++;
        if (forced !== 1'b0) begin fails++; $display("FAIL forced_pre got %b exp 0", forced); end
        wr_en = 1'b1; wr_row = 3'd7; wr_data = 8'h55; commit = 1'b1;
        tick();
        wr_en = 1'b0; commit = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            tests++;
            if ({pending, swap_done} !== 2'b10) begin
                fails++; $display("FAIL timeout_wait cyc %0d got %b exp 10", i, {pending, swap_done});
            end
        end
        tick();
        tests++;
        if ({pending, swap_done, forced} !== 3'b011) begin
            fails++; $display("FAIL timeout_swap got %b exp 011", {pending, swap_done, forced});
        end
        tests++;
        if (frame !== 64'h55402010080402AA) begin fails++; $display("FAIL timeout_frame got %h exp 55402010080402aa", frame); end
        tick();
        tests++;
        if ({forced, swap_done} !== 2'b10) begin fails++; $display("FAIL forced_sticky got %b exp 10", {forced, swap_done}); end
    endtask

    task automatic test_reset_pending();
        wr_en = 1'b1; wr_row = 3'd0; wr_data = 8'h11; commit = 1'b1;
        tick();
        wr_en = 1'b0; commit = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        tests++;
        if ({frame, pending, wr_ready, forced} !== {64'h0, 3'b010}) begin
            fails++; $display("FAIL rst_pending got %h %b exp 0 010", frame, {pending, wr_ready, forced});
        end
        frame_sync = 1'b1; tick(); frame_sync = 1'b0;
        tests++;
        if ({frame, pending, swap_done} !== {64'h0, 2'b00}) begin
            fails++; $display("FAIL rst_then_sync got %h %b exp 0 00", frame, {pending, swap_done});
        end
    endtask

    task automatic test_ping_pong();
        p_wr_en = 1'b1; p_wr_row = 3'd0; p_wr_data = 8'h3C; tick();
        p_wr_row = 3'd5; p_wr_data = 8'hC3; p_commit = 1'b1; tick();
        p_wr_en = 1'b0; p_commit = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        tests++;
        if ({p_pending, p_forced} !== 2'b10) begin fails++; $display("FAIL pp_no_timeout got %b exp 10", {p_pending, p_forced}); end
        p_sync = 1'b1; tick(); p_sync = 1'b0;
        tests++;
        if (p_frame !== 64'h0000C3000000003C) begin fails++; $display("FAIL pp_swap1 got %h exp 0000c3000000003c", p_frame); end
        p_commit = 1'b1; tick(); p_commit = 1'b0;
        p_sync = 1'b1; tick(); p_sync = 1'b0;
        tests++;
        if ({p_frame, p_swap_done} !== {64'h0, 1'b1}) begin fails++; $display("FAIL pp_swap2 got %h %b exp 0 1", p_frame, p_swap_done); end
        p_commit = 1'b1; tick(); p_commit = 1'b0;
        p_sync = 1'b1; tick(); p_sync = 1'b0;
        tests++;
        if (p_frame !== 64'h0000C3000000003C) begin fails++; $display("FAIL pp_swap3 got %h exp 0000c3000000003c", p_frame); end
    endtask

    initial begin
        {rst, wr_en, commit, frame_sync, wr_row, wr_data} = '0;
        {p_rst, p_wr_en, p_commit, p_sync, p_wr_row, p_wr_data} = '0;
        test_reset();
        test_write_commit();
        test_wait_write_drop();
        test_commit_sync_same();
        test_timeout();
        test_reset_pending();
        test_ping_pong();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
